jpeg_rle_encoder: RTL

JPEG_RLE_ENCODER -- requirements
Module: jpeg_rle_encoder

---
 rtl/jpeg_rle_encoder.sv | 191 +++++++++++++++++++
 1 files changed

// File: rtl/jpeg_rle_encoder.sv
// JPEG run-length / magnitude-category encoder for one zigzag-ordered block.
// Emits a DC difference symbol, then AC (run, size, amp) symbols with ZRL
// insertion for runs of 16+ zeros, and EOB when the block ends in zeros.
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   in_valid/in_ready     block handshake; in_data holds PIXEL_COUNT coefficients
//   in_chan               0=Y, 1=Cb, 2=Cr (3 treated as Y)
//   dc_clear              clears all DC predictors
//   out_valid/out_ready   symbol handshake
//   sym_run/size/amp      symbol fields; sym_is_dc, sym_last, sym_chan qualify it
module jpeg_rle_encoder #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned PIXEL_COUNT = 64
) (
  input  logic                              clk,
  input  logic                              reset_n,
  input  logic                              in_valid,
  output logic                              in_ready,
  input  logic [DATA_WIDTH*PIXEL_COUNT-1:0] in_data,
  input  logic [1:0]                        in_chan,
  input  logic                              dc_clear,
  output logic                              out_valid,
  input  logic                              out_ready,
  output logic [3:0]                        sym_run,
  output logic [3:0]                        sym_size,
  output logic [10:0]                       sym_amp,
  output logic                              sym_is_dc,
  output logic                              sym_last,
  output logic [1:0]                        sym_chan
);

  localparam int unsigned KW = $clog2(PIXEL_COUNT);
  localparam logic [KW-1:0] LastK = KW'(PIXEL_COUNT - 1);
  localparam logic [KW-1:0] Run16 = KW'(16);
  localparam logic signed [DATA_WIDTH-1:0] CoefMax = DATA_WIDTH'(2047);
  localparam logic signed [DATA_WIDTH-1:0] CoefMin = DATA_WIDTH'(-2047);

  typedef enum logic [2:0] {StIdle, StDc, StAc, StZrl, StEob} state_e;

  function automatic logic signed [11:0] clamp_coef(input logic signed [DATA_WIDTH-1:0] x);
    if (x > CoefMax) return 12'sd2047;
    else if (x < CoefMin) return -12'sd2047;
    else return x[11:0];
  endfunction

  // Returns {size, amp}; negative values use the one's-complement style (v-1) amplitude.
  function automatic logic [14:0] encode(input logic signed [11:0] v);
    logic [11:0] vu, mag, vm1;
    logic [3:0]  size;
    logic [10:0] mask, amp;
    vu   = v;
    mag  = vu[11] ? (~vu + 12'd1) : vu;
    size = 4'd0;
    for (int i = 0; i < 11; i++) if (mag[i]) size = 4'(i + 1);
    mask = 11'((12'd1 << size) - 12'd1);
    vm1  = vu - 12'd1;
    amp  = vu[11] ? (vm1[10:0] & mask) : vu[10:0];
    return {size, amp};
  endfunction

  state_e                            state_q, state_d;
  logic [KW-1:0]                     k_q, k_d;
  logic [KW-1:0]                     run_q, run_d;
  logic [DATA_WIDTH*PIXEL_COUNT-1:0] blk_q;
  logic [1:0]                        chan_q;
  logic signed [11:0]                dc_diff_q;
  logic signed [11:0]                pred_q [3];

  logic [1:0]         in_chan_n;
  logic               accept, fire;
  logic signed [11:0] coef, dc_new, dc_cur, pred_sel, dc_diff_new;
  logic signed [12:0] diff_wide;
  logic [14:0]        ac_enc, dc_enc;

  assign in_chan_n = (in_chan == 2'd3) ? 2'd0 : in_chan;
  assign accept    = in_valid && in_ready;
  assign fire      = out_valid && out_ready;
  assign coef      = clamp_coef(blk_q[int'(k_q) * DATA_WIDTH +: DATA_WIDTH]);
  assign dc_cur    = clamp_coef(blk_q[DATA_WIDTH-1:0]);
  assign ac_enc    = encode(coef);
  assign dc_enc    = encode(dc_diff_q);

  // The DC difference is captured at accept so a later dc_clear cannot disturb
  // a DC symbol that is waiting on out_ready.
  assign dc_new    = clamp_coef(in_data[DATA_WIDTH-1:0]);
  assign pred_sel  = dc_clear ? 12'sd0 : pred_q[in_chan_n];
  assign diff_wide = $signed({dc_new[11], dc_new}) - $signed({pred_sel[11], pred_sel});

  always_comb begin
    if (diff_wide > 13'sd2047) dc_diff_new = 12'sd2047;
    else if (diff_wide < -13'sd2047) dc_diff_new = -12'sd2047;
    else dc_diff_new = diff_wide[11:0];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      k_q       <= '0;
      run_q     <= '0;
      blk_q     <= '0;
      chan_q    <= '0;
      dc_diff_q <= '0;
      for (int i = 0; i < 3; i++) pred_q[i] <= '0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      run_q   <= run_d;
      if (accept) begin
        blk_q     <= in_data;
        chan_q    <= in_chan_n;
        dc_diff_q <= dc_diff_new;
      end
      // A clear always wins so the next block starts from zero predictors.
      if (dc_clear) begin
        for (int i = 0; i < 3; i++) pred_q[i] <= '0;
      end else if (state_q == StDc && fire) begin
        pred_q[chan_q] <= dc_cur;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    run_d     = run_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    sym_run   = '0;
    sym_size  = '0;
    sym_amp   = '0;
    sym_is_dc = 1'b0;
    sym_last  = 1'b0;
    sym_chan  = '0;
    unique case (state_q)
      StIdle: begin
        in_ready = 1'b1;
        if (in_valid) state_d = StDc;
      end
      StDc: begin
        out_valid = 1'b1;
        sym_size  = dc_enc[14:11];
        sym_amp   = dc_enc[10:0];
        sym_is_dc = 1'b1;
        sym_chan  = chan_q;
        if (out_ready) begin
          state_d = StAc;
          k_d     = KW'(1);
          run_d   = '0;
        end
      end
      StAc: begin
        sym_chan = chan_q;
        if (coef == 12'sd0) begin
          run_d = run_q + 1'b1;
          if (k_q == LastK) state_d = StEob;
          else k_d = k_q + 1'b1;
        end else if (run_q >= Run16) begin
          state_d = StZrl;
        end else begin
          out_valid = 1'b1;
          sym_run   = run_q[3:0];
          sym_size  = ac_enc[14:11];
          sym_amp   = ac_enc[10:0];
          sym_last  = (k_q == LastK);
          if (out_ready) begin
            run_d = '0;
            if (k_q == LastK) state_d = StIdle;
            else k_d = k_q + 1'b1;
          end
        end
      end
      StZrl: begin
        out_valid = 1'b1;
        sym_run   = 4'd15;
        sym_chan  = chan_q;
        if (out_ready) begin
          run_d = run_q - Run16;
          if (run_q - Run16 < Run16) state_d = StAc;
        end
      end
      StEob: begin
        out_valid = 1'b1;
        sym_last  = 1'b1;
        sym_chan  = chan_q;
        if (out_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

endmodule
